receive_beamformer: RTL

Receive-side counterpart of the transmit delay beamformer. Takes one time-aligned sample per receiver per valid strobe and delays each channel by its own programmable number of samples. It then sums all channels at full precision into one steered beam sample. It sits between the receiver ADC front-end and the downstream envelope/peak-detect chain; delay values come from the steering-angle control logic.

---
 rtl/beamformer_pkg.sv | 14 +
 rtl/rx_delay_line.sv | 42 ++++
 rtl/receive_beamformer.sv | 75 +++++++
 3 files changed

// File: rtl/beamformer_pkg.sv
// Shared beamformer types and sizing helpers, common to the transmit and receive paths.
package beamformer_pkg;

  localparam int SAMPLE_WIDTH  = 16;
  localparam int DEFAULT_DEPTH = 64;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // Sum width that can hold num_receivers full-scale samples without overflow.
  function automatic int sum_width(input int num_receivers, input int sample_width);
    return sample_width + $clog2(num_receivers);
  endfunction

endpackage

// File: rtl/rx_delay_line.sv
// One receiver channel: circular sample buffer with registered read, zero-delay
// forwarding, and masking of samples that predate the last reset.
module rx_delay_line #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 64,
  parameter int DELAY_WIDTH  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [DELAY_WIDTH-1:0]  wr_ptr,
  input  logic [DELAY_WIDTH-1:0]  delay,
  input  logic [DELAY_WIDTH:0]    fill,
  output logic [SAMPLE_WIDTH-1:0] delayed
);
  import beamformer_pkg::*;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [DELAY_WIDTH-1:0]  rd_addr;
  logic                    masked;

  assign rd_addr = wr_ptr - delay;
  assign masked  = {1'b0, delay} > fill;

  // Buffer is never cleared; the fill mask hides anything written before reset.
  always_ff @(posedge clk) begin
    if (sample_valid) mem[wr_ptr] <= sample;
  end

  // A nonzero delay never reads the slot being written, so only d==0 needs a bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delayed <= '0;
    end else if (sample_valid) begin
      if (masked)             delayed <= '0;
      else if (delay == '0)   delayed <= sample;
      else                    delayed <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/receive_beamformer.sv
// Receive delay-and-sum beamformer: per-channel programmable sample delay,
// full-precision sum, fixed two-cycle latency from accepted sample to beam strobe.
module receive_beamformer #(
  parameter int NUM_RECEIVERS = 4,
  parameter int SAMPLE_WIDTH  = beamformer_pkg::SAMPLE_WIDTH,
  parameter int DEPTH         = beamformer_pkg::DEFAULT_DEPTH,
  parameter int DELAY_WIDTH   = $clog2(DEPTH),
  parameter int SUM_WIDTH     = beamformer_pkg::sum_width(NUM_RECEIVERS, SAMPLE_WIDTH)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        sample_valid_in,
  input  logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0]  samples_in,
  input  logic                                        delay_load,
  input  logic [NUM_RECEIVERS-1:0][DELAY_WIDTH-1:0]   delay_in,
  output logic signed [SUM_WIDTH-1:0]                 beam_out,
  output logic                                        beam_valid_out
);
  import beamformer_pkg::*;

  localparam int FILL_WIDTH = DELAY_WIDTH + 1;

  logic [DELAY_WIDTH-1:0]                      wr_ptr;
  logic [FILL_WIDTH-1:0]                       fill_cnt;
  logic [NUM_RECEIVERS-1:0][DELAY_WIDTH-1:0]   delays;
  logic                                        stage1_valid;
  logic [SAMPLE_WIDTH-1:0]                     delayed [NUM_RECEIVERS];
  logic signed [SUM_WIDTH-1:0]                 sum;

  for (genvar i = 0; i < NUM_RECEIVERS; i++) begin : g_chan
    rx_delay_line #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .DEPTH        (DEPTH),
      .DELAY_WIDTH  (DELAY_WIDTH)
    ) u_line (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid_in),
      .sample       (samples_in[i]),
      .wr_ptr       (wr_ptr),
      .delay        (delays[i]),
      .fill         (fill_cnt),
      .delayed      (delayed[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      sum = sum + {{(SUM_WIDTH-SAMPLE_WIDTH){delayed[i][SAMPLE_WIDTH-1]}}, delayed[i]};
    end
  end

  // Delay registers change at the edge, so a coincident sample still sees the old delays.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      delays         <= '0;
      stage1_valid   <= 1'b0;
      beam_valid_out <= 1'b0;
      beam_out       <= '0;
    end else begin
      stage1_valid   <= sample_valid_in;
      beam_valid_out <= stage1_valid;
      if (stage1_valid) beam_out <= sum;
      if (sample_valid_in) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != FILL_WIDTH'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
      end
      if (delay_load) delays <= delay_in;
    end
  end

endmodule
